// File: rtl/uart_wb_pkg.sv
// ----------------------------------------------------------------------------
// uart_wb_pkg
// Shared types and constants for the UART Wishbone poller.
//   state_e        : poller FSM states
//   REG_DATA       : byte offset of the UART data register
//   REG_STATUS     : byte offset of the UART status register
//   STAT_RX_READY  : status bit, received byte available
//   STAT_TX_IDLE   : status bit, transmitter idle
// ----------------------------------------------------------------------------
package uart_wb_pkg;

  typedef enum logic [2:0] {
    GAP    = 3'd0,
    POLL   = 3'd1,
    DECIDE = 3'd2,
    RD     = 3'd3,
    WR     = 3'd4
  } state_e;

  localparam logic [7:0] REG_DATA      = 8'h00;
  localparam logic [7:0] REG_STATUS    = 8'h04;
  localparam int         STAT_RX_READY = 0;
  localparam int         STAT_TX_IDLE  = 5;

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with count-based full/empty and a combinational head.
//   clk_i / rst_ni : clock, synchronous active-low reset
//   push_i, data_i : write a word (ignored when full unless popping too)
//   pop_i          : drop the head word (ignored when empty)
//   data_o         : current head word
//   empty_o/full_o : occupancy flags
// DEPTH must be a power of 2 so the pointers wrap by themselves.
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign data_o  = mem_q[rd_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: the storage array has no reset; the count and pointers alone decide
  // which entries are valid, so resetting the data would only cost logic.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_wb_poller.sv
// ----------------------------------------------------------------------------
// uart_wb_poller
// Wishbone classic master that polls a UART controller's status register,
// drains received bytes into a small RX FIFO and writes client TX bytes when
// the transmitter reports idle.
//   clk_i, rst_ni           : clock, synchronous active-low reset
//   wb_*                    : Wishbone classic master port (sel fixed 0001)
//   tx_valid_i/tx_data_i    : client byte offer, accepted while tx_ready_o
//   tx_ready_o              : TX holding register empty
//   rx_valid_o/rx_data_o    : RX FIFO head, popped by rx_ready_i
//   err_o                   : sticky bus timeout flag
// Optional feature: define UART_WB_POLLER_TIMEOUT_EN to abort a bus cycle
// that sees no ACK within TIMEOUT_CYCLES; otherwise err_o is tied 0.
// ----------------------------------------------------------------------------
module uart_wb_poller
  import uart_wb_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1000_0000,
  parameter int                    RX_DEPTH       = 4,
  parameter int                    POLL_GAP       = 8,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_we_o,
  input  logic                    tx_valid_i,
  input  logic [7:0]              tx_data_i,
  output logic                    tx_ready_o,
  output logic                    rx_valid_o,
  output logic [7:0]              rx_data_o,
  input  logic                    rx_ready_i,
  output logic                    err_o
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;

  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       status_q, status_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             bus_active, timeout, rx_push, fifo_full, fifo_empty;
  logic             unused_bits;

  assign bus_active = (state_q == POLL) || (state_q == RD) || (state_q == WR);

  // Address, we and write data depend only on the state and the holding
  // register, which cannot change while a write is in flight.
  assign wb_cyc_o   = bus_active;
  assign wb_stb_o   = bus_active;
  assign wb_we_o    = (state_q == WR);
  assign wb_sel_o   = SEL_W'(1);
  assign wb_dat_o   = (state_q == WR) ? DATA_WIDTH'(hold_q) : '0;
  assign tx_ready_o = !hold_vld_q;
  assign rx_valid_o = !fifo_empty;

  always_comb begin
    wb_adr_o = '0;
    case (state_q)
      POLL:    wb_adr_o = BASE_ADDR + ADDR_WIDTH'(REG_STATUS);
      RD, WR:  wb_adr_o = BASE_ADDR + ADDR_WIDTH'(REG_DATA);
      default: wb_adr_o = '0;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    status_d   = status_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    rx_push    = 1'b0;

    if (tx_valid_i && !hold_vld_q) begin
      hold_d     = tx_data_i;
      hold_vld_d = 1'b1;
    end

    case (state_q)
      GAP: begin
        // At least one GAP cycle, even when POLL_GAP is 0.
        if (int'(gap_q) + 1 >= POLL_GAP) begin
          state_d = POLL;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      POLL: begin
        if (wb_ack_i) begin
          status_d = wb_dat_i[7:0];
          state_d  = DECIDE;
        end else if (timeout) begin
          state_d = GAP;
        end
      end
      DECIDE: begin
        // Draining RX comes first so the UART receiver never overruns.
        if (status_q[STAT_RX_READY] && !fifo_full)        state_d = RD;
        else if (hold_vld_q && status_q[STAT_TX_IDLE])    state_d = WR;
        else                                              state_d = GAP;
      end
      RD: begin
        if (wb_ack_i) begin
          rx_push = 1'b1;
          state_d = GAP;
        end else if (timeout) begin
          state_d = GAP;
        end
      end
      WR: begin
        if (wb_ack_i) begin
          hold_vld_d = 1'b0;
          state_d    = GAP;
        end else if (timeout) begin
          state_d = GAP;
        end
      end
      default: state_d = GAP;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= GAP;
      gap_q      <= '0;
      status_q   <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      status_q   <= status_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

`ifdef UART_WB_POLLER_TIMEOUT_EN
  localparam int TO_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);

  logic [TO_W-1:0] to_q, to_d;
  logic            err_q;

  // The cycle is abandoned after it has been open TIMEOUT_CYCLES cycles.
  assign timeout = bus_active && !wb_ack_i && (int'(to_q) + 1 >= TIMEOUT_CYCLES);
  assign to_d    = (bus_active && !wb_ack_i && !timeout) ? to_q + TO_W'(1) : '0;
  assign err_o   = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q <= to_d;
      if (timeout) err_q <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rx_push),
    .data_i  (wb_dat_i[7:0]),
    .pop_i   (rx_ready_i),
    .data_o  (rx_data_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Only the low byte of read data and two status bits carry meaning.
  assign unused_bits = ^{wb_dat_i[DATA_WIDTH-1:8], status_q[7:6], status_q[4:1]};

endmodule

// File: tb/tb_uart_wb_poller.sv
// ----------------------------------------------------------------------------
// tb_uart_wb_poller
// Self-checking bench for uart_wb_poller. A behavioural slave answers the bus;
// a transaction-level model predicts which access comes next and when, the RX
// byte stream and the TX byte stream, and every output is compared to it.
// ----------------------------------------------------------------------------
module tb_uart_wb_poller;

  localparam int          AW       = 32;
  localparam int          DW       = 32;
  localparam logic [31:0] BASE     = 32'h1000_0000;
  localparam int          DEPTH    = 4;
  localparam int          PGAP     = 3;
  localparam int          TO_CYC   = 20;
  localparam int          G        = (PGAP == 0) ? 1 : PGAP;
  localparam int          K_POLL   = 0;
  localparam int          K_RD     = 1;
  localparam int          K_WR     = 2;
  localparam int          K_BAD    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_cyc, wb_stb, wb_ack, wb_we;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic [3:0]    wb_sel;
  logic          tx_valid, tx_ready, rx_valid, rx_ready, err;
  logic [7:0]    tx_data, rx_data;

  // slave side
  logic [7:0]    slv_status;
  logic [31:0]   rd_word;
  int            slv_wait;
  int            wcnt;
  logic          hold_wr_ack;
  logic          spur;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  // model state
  logic          mon_en;
  logic [7:0]    rxq[$];
  logic [7:0]    txq[$];
  logic          hold_pend;
  int            exp_kind, exp_start;
  logic          dec_due;
  int            dec_cycle;
  logic [7:0]    last_status;
  logic          in_bus, prev_ack;
  int            cur_kind;
  logic [31:0]   st_adr, st_dat, last_wr_dat;
  logic          st_we;
  int            n_poll, n_rd, n_wr;

  always #5 clk = ~clk;

  uart_wb_poller #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .BASE_ADDR      (BASE),
    .RX_DEPTH       (DEPTH),
    .POLL_GAP       (PGAP),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wb_cyc_o   (wb_cyc),
    .wb_stb_o   (wb_stb),
    .wb_ack_i   (wb_ack),
    .wb_adr_o   (wb_adr),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_o   (wb_sel),
    .wb_we_o    (wb_we),
    .tx_valid_i (tx_valid),
    .tx_data_i  (tx_data),
    .tx_ready_o (tx_ready),
    .rx_valid_o (rx_valid),
    .rx_data_o  (rx_data),
    .rx_ready_i (rx_ready),
    .err_o      (err)
  );

  // Slave: status register at BASE+4, data register everywhere else.
  assign wb_dat_i = (wb_adr == BASE + 32'd4) ? {24'h0, slv_status} : rd_word;
  assign wb_ack   = (wb_cyc && wb_stb && (wcnt >= slv_wait) && !(hold_wr_ack && wb_we))
                 || (spur && !wb_cyc);

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (wb_cyc && wb_stb && !wb_ack) wcnt <= wcnt + 1;
    else                             wcnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic int classify(input logic [31:0] adr, input logic we);
    if (adr == BASE + 32'd4 && !we) return K_POLL;
    if (adr == BASE && !we)         return K_RD;
    if (adr == BASE && we)          return K_WR;
    return K_BAD;
  endfunction

  // Monitor and reference model, evaluated mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      // 1. outputs against the model state
      check("tx_ready", tx_ready, !hold_pend);
      check("rx_valid", rx_valid, rxq.size() != 0);
      if (rxq.size() != 0) check("rx_data", rx_data, rxq[0]);
      check("err", err, 0);

      // 2. next-access decision, one cycle after the status poll completed
      if (dec_due && cyc_n == dec_cycle) begin
        dec_due = 1'b0;
        if (last_status[0] && rxq.size() < DEPTH)  exp_kind = K_RD;
        else if (hold_pend && last_status[5])      exp_kind = K_WR;
        else                                       exp_kind = K_POLL;
        exp_start = (exp_kind == K_POLL) ? cyc_n + 1 + G : cyc_n + 1;
      end

      // 3. bus protocol
      if (prev_ack) check("idle_after_ack", {wb_cyc, wb_stb}, 2'b00);
      prev_ack = 1'b0;
      if (wb_cyc && !in_bus) begin
        in_bus   = 1'b1;
        st_adr   = wb_adr;
        st_we    = wb_we;
        st_dat   = wb_dat_o;
        cur_kind = classify(wb_adr, wb_we);
        check("access_kind", cur_kind, exp_kind);
        check("access_start", cyc_n, exp_start);
        check("stb_with_cyc", wb_stb, 1);
        check("sel", wb_sel, 4'b0001);
      end else if (in_bus) begin
        check("cyc_held", wb_cyc, 1);
      end
      if (in_bus && wb_ack) begin
        check("adr_stable", wb_adr, st_adr);
        check("we_dat_stable", {wb_we, wb_dat_o}, {st_we, st_dat});
        in_bus   = 1'b0;
        prev_ack = 1'b1;
        if (cur_kind == K_POLL) begin
          last_status = slv_status;
          dec_due     = 1'b1;
          dec_cycle   = cyc_n + 1;
          n_poll++;
        end else begin
          if (cur_kind == K_RD) begin
            rxq.push_back(rd_word[7:0]);
            n_rd++;
          end else if (cur_kind == K_WR) begin
            last_wr_dat = wb_dat_o;
            if (txq.size() != 0) begin
              check("wr_data", wb_dat_o, {24'h0, txq[0]});
              void'(txq.pop_front());
            end else begin
              check("wr_without_byte", 1, 0);
            end
            hold_pend = 1'b0;
            n_wr++;
          end
          exp_kind  = K_POLL;
          exp_start = cyc_n + 1 + G;
        end
      end

      // 4. client handshakes completing at the coming edge
      if (rx_valid && rx_ready && rxq.size() != 0) void'(rxq.pop_front());
      if (tx_valid && tx_ready) begin
        txq.push_back(tx_data);
        hold_pend = 1'b1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called one step after a posedge in the first cycle with rst_n high.
  task automatic mon_start();
    rxq.delete();
    txq.delete();
    hold_pend = 1'b0;
    dec_due   = 1'b0;
    in_bus    = 1'b0;
    prev_ack  = 1'b0;
    exp_kind  = K_POLL;
    exp_start = cyc_n + G;
    mon_en    = 1'b1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    step(3);
    rst_n = 1'b1;
    mon_start();
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    while (!tx_ready && n < 200) begin
      step(1);
      n++;
    end
    check("send_accept", tx_ready, 1);
    step(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rd(input int target, input int budget);
    int n = 0;
    while (n_rd < target && n < budget) begin
      step(1);
      n++;
    end
    check("wait_rd", n_rd >= target, 1);
  endtask

  task automatic wait_wr(input int target, input int budget);
    int n = 0;
    while (n_wr < target && n < budget) begin
      step(1);
      n++;
    end
    check("wait_wr", n_wr >= target, 1);
  endtask

  task automatic drain();
    slv_status = 8'h20;
    rx_ready   = 1'b1;
    step(30);
    rx_ready   = 1'b0;
    check("drained", rx_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_rd, b_wr, b_poll, n;
    rst_n       = 1'b0;
    mon_en      = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    rx_ready    = 1'b0;
    slv_status  = 8'h20;
    rd_word     = 32'h0;
    slv_wait    = 0;
    hold_wr_ack = 1'b0;
    spur        = 1'b0;
    n_poll = 0; n_rd = 0; n_wr = 0;
    step(3);

    // reset state
    check("rst_cyc_stb", {wb_cyc, wb_stb, wb_we}, 3'b000);
    check("rst_adr", wb_adr, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_sel", wb_sel, 4'b0001);
    check("rst_flags", {tx_ready, rx_valid, err}, 3'b100);
    rst_n = 1'b1;
    mon_start();

    // status polling only, TX idle, nothing to send
    b_poll = n_poll; b_rd = n_rd; b_wr = n_wr;
    step(10 * (G + 2));
    check("idle_no_data_access", (n_rd - b_rd) + (n_wr - b_wr), 0);
    check("idle_polls", (n_poll - b_poll) >= 9, 1);

    // one received byte
    b_rd = n_rd;
    rd_word = 32'h4141_4141;
    slv_status = 8'h21;
    wait_rd(b_rd + 1, 50);
    slv_status = 8'h20;
    step(1);
    check("rx_first_valid", rx_valid, 1);
    check("rx_first_data", rx_data, 8'h41);
    step(20);
    check("rx_single_read", n_rd - b_rd, 1);
    drain();

    // TX waits for idle
    slv_status = 8'h00;
    b_wr = n_wr;
    send(8'h55);
    check("tx_held", tx_ready, 0);
    step(5 * (G + 2));
    check("tx_not_idle_no_write", n_wr - b_wr, 0);
    slv_status = 8'h20;
    wait_wr(b_wr + 1, 50);
    step(1);
    check("tx_written_once", n_wr - b_wr, 1);
    check("tx_wr_word", last_wr_dat, 32'h0000_0055);
    check("tx_ready_after", tx_ready, 1);

    // FIFO full gates data reads
    slv_status = 8'h21;
    rx_ready = 1'b0;
    b_rd = n_rd;
    rd_word = 32'h0000_00c3;
    step(80);
    check("full_reads", n_rd - b_rd, DEPTH);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(80);
    check("full_pop_one_more", n_rd - b_rd, DEPTH + 1);
    drain();

    // RX beats TX
    slv_status = 8'h21;
    b_rd = n_rd; b_wr = n_wr;
    send(8'ha7);
    wait_rd(b_rd + 1, 50);
    check("rd_before_wr", n_wr - b_wr, 0);
    slv_status = 8'h20;
    wait_wr(b_wr + 1, 50);
    drain();

    // random traffic with wait states and stray ACKs
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 4))
        0: slv_status = 8'h00;
        1: slv_status = 8'h01;
        2: slv_status = 8'h20;
        3: slv_status = 8'h21;
        default: slv_status = 8'($urandom);
      endcase
      rd_word  = $urandom;
      slv_wait = $urandom_range(0, 2);
      rx_ready = ($urandom_range(0, 2) != 0);
      spur     = ($urandom_range(0, 7) == 0);
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
      step(1);
    end
    tx_valid = 1'b0;
    spur     = 1'b0;
    slv_wait = 0;
    drain();
    check("random_tx_flushed", tx_ready, 1);

    // reset in the middle of a data write
    slv_status  = 8'h20;
    hold_wr_ack = 1'b1;
    send(8'h3c);
    n = 0;
    while (!(in_bus && cur_kind == K_WR) && n < 100) begin
      step(1);
      n++;
    end
    check("wr_started", in_bus && cur_kind == K_WR, 1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    step(1);
    check("rst_wr_cyc_stb", {wb_cyc, wb_stb}, 2'b00);
    check("rst_wr_tx_ready", tx_ready, 1);
    hold_wr_ack = 1'b0;
    step(1);
    rst_n = 1'b1;
    mon_start();
    step(3 * (G + 2));

`ifdef UART_WB_POLLER_TIMEOUT_EN
    // ACK withheld: the poll is abandoned and the error sticks
    mon_en   = 1'b0;
    slv_wait = 100000;
    n = 0;
    while (!wb_cyc && n < 50) begin
      step(1);
      n++;
    end
    n = 0;
    while (wb_cyc && n < 1000) begin
      step(1);
      n++;
    end
    check("timeout_len", n, TO_CYC);
    check("timeout_err", err, 1);
    step(3 * TO_CYC);
    check("timeout_err_sticky", err, 1);
    slv_wait = 0;
    do_reset();
    step(2 * (G + 2));
`endif

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
